bcd_stopwatch_ctrl: RTL
=======================

// Module: bcd_stopwatch_ctrl
// PURPOSE
//   Run/pause/clear sequencer for a cascaded chain of BCD decade digits.
//   Divides CLK down to a count tick with a prescaler and ripples decade carries across DIGITS digits.
//   Provides an optional lap-freeze display register.
//   Sits between the push-button/command logic and the 7-segment display driver.
// PARAMETERS
//   DIGITS    4   number of BCD decades; Count/Display width = 4*DIGITS
//   PRESCALE  10  CLK cycles per count tick (>=2)
// PORTS
//   CLK        in   1         clock; all state updates on posedge CLK
//   Reset      in   1         synchronous, active-high reset
//   StartStop  in   1         level cmd; rising edge toggles run/pause
//   Clear      in   1         level cmd, active-high; rising edge zeroes the counter
//   Lap        in   1         level cmd; rising edge toggles display freeze (LAP_EN only)
//   Count      out  4*DIGITS  live BCD value; digit 0 = bits [3:0] (least significant)
//   Display    out  4*DIGITS  value for the display driver
//   Running    out  1         1 while in state RUN
//   Tick       out  1         1-cycle pulse on each count increment
//   Overflow   out  1         sticky; set on wrap from all-9s to all-0s
// BEHAVIOUR
//   - Reset (sync, active-high, beats every cmd): state=IDLE; Count=0, prescaler=0, freeze=0,
//     edge regs=0; Running=0, Tick=0, Overflow=0, Display=0.
//   - Cmd edge detect:
//     - each cmd is registered once; cmd_rise = cmd & ~cmd_q.
//     - A held level acts once only.
//     - The state change is visible on the edge that samples the rise.
//   - FSM states IDLE, RUN, PAUSE:
//     - IDLE -StartStop-> RUN
//     - RUN -StartStop-> PAUSE
//     - PAUSE -StartStop-> RUN
//     - any state -Clear-> IDLE
//   - Clear has priority over StartStop and Lap in the same cycle:
//     - zeroes Count, prescaler, Overflow and freeze;
//     - lands in IDLE, even from RUN.
//   - Prescaler runs only in RUN, counting 0..PRESCALE-1:
//     - holds its value in PAUSE (resume continues the partial period);
//     - the cycle it equals PRESCALE-1 it wraps to 0, Count increments and registered Tick=1
//       for one cycle.
//   - Decade cascade:
//     - digit i increments when the tick fires and all digits below i equal 9;
//     - a digit at 9 that increments goes to 0; other digits hold;
//     - digit values are always 0..9, never 10..15.
//   - Wrap: all-9s + tick -> all-0s and Overflow=1 on the same edge. Counting continues;
//     Overflow holds until Clear/Reset.
//   - Running = (state==RUN), registered.
//   - Latency:
//     - StartStop rise -> Running=1 after 1 edge;
//     - first Tick PRESCALE cycles after entering RUN from a zero prescaler.
//   - Reset mid-count: on the next edge everything is at its reset value; no residual Tick.
// CONFIGURATION
//   LAP_STOPWATCH_EN defined:
//     - freeze register + Display latch.
//     - In RUN, a Lap rise with freeze=0 copies Count into Display and sets freeze=1.
//       Display then holds while Count keeps running.
//     - A Lap rise with freeze=1 clears freeze; Display tracks Count again.
//     - Lap is ignored in IDLE/PAUSE; PAUSE keeps the current freeze.
//     - Display = freeze ? latch : Count.
//   LAP_STOPWATCH_EN undefined:
//     - Lap is ignored; no freeze/latch logic;
//     - Display = Count (combinational alias).
// TESTING (bench: DIGITS=2, PRESCALE=4)
//   - Reset 3 cycles, StartStop rise -> Running=1 next edge; Tick every 4 cycles;
//     Count 00->01->...->09->10 (digit0 wraps, digit1=1).
//   - Run to 99, one more tick -> Count=00, Overflow=1; after 4 more cycles Count=01,
//     Overflow still 1; Clear rise -> Count=00, Overflow=0, IDLE.
//   - Count=05 with prescaler=2; StartStop rise -> PAUSE, Count/prescaler frozen for 20 cycles.
//     StartStop rise -> next Tick after 2 cycles, Count=06.
//   - StartStop and Clear rise on the same cycle in RUN -> IDLE, Count=00, Running=0.
//     StartStop held high for 10 cycles -> a single toggle only.
//   - LAP_STOPWATCH_EN, Count=23: Lap rise -> Display=23 held while Count reaches 27;
//     second Lap rise -> Display=Count. Repeat undefined: Display=Count always.
//   - Reset asserted mid-run at Count=47 -> next edge Count=00, Running=0, Tick=0, Display=00.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl_if.sv
// Command/status bundle between the push-button logic, the stopwatch
// sequencer and the 7-segment display driver.
interface bcd_stopwatch_ctrl_if #(
  parameter int DIGITS = 4
);
  logic                  StartStop;
  logic                  Clear;
  logic                  Lap;
  logic [4*DIGITS-1:0]   Count;
  logic [4*DIGITS-1:0]   Display;
  logic                  Running;
  logic                  Tick;
  logic                  Overflow;

  // Command side: issues the button levels, observes the stopwatch.
  modport master (
    output StartStop, Clear, Lap,
    input  Count, Display, Running, Tick, Overflow
  );

  // Stopwatch side: consumes the button levels, produces count/status.
  modport slave (
    input  StartStop, Clear, Lap,
    output Count, Display, Running, Tick, Overflow
  );
endinterface

// File: rtl/bcd_stopwatch_ctrl.sv
// Run/pause/clear sequencer for a chain of DIGITS cascaded BCD decades.
// A prescaler divides CLK down to a count tick; decade carries ripple
// from digit 0 (bits [3:0]) upward. Optional lap-freeze display latch is
// compiled in when LAP_STOPWATCH_EN is defined; otherwise Display is a
// direct alias of Count.
module bcd_stopwatch_ctrl #(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic                 CLK,
  input  logic                 Reset,
  bcd_stopwatch_ctrl_if.slave  bus
);

  localparam int CW = 4 * DIGITS;
  localparam int PW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic            r_start_q;
  logic            r_clear_q;
  logic            w_start_rise;
  logic            w_clear_rise;

  logic [PW-1:0]   r_presc;
  logic [CW-1:0]   r_count;
  logic            r_running;
  logic            r_tick;
  logic            r_overflow;

  logic            w_run_en;
  logic            w_tick_fire;
  logic [CW:0]     w_inc;

  // Increment a packed BCD value by one; returns {carry_out, result}.
  // A digit advances only when every lower digit was 9, so digits stay 0..9.
  function automatic logic [CW:0] bcd_inc(input logic [CW-1:0] val);
    logic [CW-1:0] res;
    logic          carry;
    res   = val;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (val[4*i +: 4] == 4'd9) begin
          res[4*i +: 4] = 4'd0;
        end else begin
          res[4*i +: 4] = val[4*i +: 4] + 4'd1;
          carry         = 1'b0;
        end
      end
    end
    return {carry, res};
  endfunction

  assign w_start_rise = bus.StartStop & ~r_start_q;
  assign w_clear_rise = bus.Clear     & ~r_clear_q;

  // Counting stops on the very edge that samples a pause or clear, so the
  // prescaler phase seen at the command is the one that is held.
  assign w_run_en    = (r_state == RUN) && !w_start_rise && !w_clear_rise;
  assign w_tick_fire = w_run_en && (r_presc == PS_LAST);
  assign w_inc       = bcd_inc(r_count);

  // State register.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; Clear outranks StartStop.
  always_comb begin
    w_state_nxt = r_state;
    if (w_clear_rise) begin
      w_state_nxt = IDLE;
    end else if (w_start_rise) begin
      case (r_state)
        IDLE:    w_state_nxt = RUN;
        RUN:     w_state_nxt = PAUSE;
        PAUSE:   w_state_nxt = RUN;
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Edge-detect registers, prescaler, decade counter and status flags.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_start_q  <= 1'b0;
      r_clear_q  <= 1'b0;
      r_presc    <= '0;
      r_count    <= '0;
      r_running  <= 1'b0;
      r_tick     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_start_q <= bus.StartStop;
      r_clear_q <= bus.Clear;
      r_running <= (w_state_nxt == RUN);
      r_tick    <= w_tick_fire;
      if (w_clear_rise) begin
        r_presc    <= '0;
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_run_en) begin
        if (r_presc == PS_LAST) begin
          r_presc <= '0;
          r_count <= w_inc[CW-1:0];
          if (w_inc[CW]) begin
            r_overflow <= 1'b1;
          end
        end else begin
          r_presc <= r_presc + PW'(1);
        end
      end
    end
  end

`ifdef LAP_STOPWATCH_EN
  logic            r_lap_q;
  logic            r_freeze;
  logic [CW-1:0]   r_lap_latch;
  logic            w_lap_rise;

  assign w_lap_rise = bus.Lap & ~r_lap_q;

  // Lap freeze: first Lap rise in RUN snapshots Count, second one releases.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_lap_q     <= 1'b0;
      r_freeze    <= 1'b0;
      r_lap_latch <= '0;
    end else begin
      r_lap_q <= bus.Lap;
      if (w_clear_rise) begin
        r_freeze <= 1'b0;
      end else if ((r_state == RUN) && w_lap_rise) begin
        if (!r_freeze) begin
          r_lap_latch <= r_count;
          r_freeze    <= 1'b1;
        end else begin
          r_freeze    <= 1'b0;
        end
      end
    end
  end

  assign bus.Display = r_freeze ? r_lap_latch : r_count;
`else
  logic w_unused_lap;
  assign w_unused_lap = bus.Lap;
  assign bus.Display  = r_count;
`endif

  assign bus.Count    = r_count;
  assign bus.Running  = r_running;
  assign bus.Tick     = r_tick;
  assign bus.Overflow = r_overflow;

endmodule
